// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, counter debounce, press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to add per-channel auto-repeat press pulses while a button is held.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]           sync1_q, sync2_q;
  logic [NUM_BTN-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]           level_q, level_d;
  logic [NUM_BTN-1:0]           press_q, press_d;
  logic [NUM_BTN-1:0]           release_q, release_d;
  logic [NUM_BTN-1:0]           rpt_fire;

  // Synchronizers run regardless of en so re-enable sees a settled level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d     = '0;
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      level_d[i] = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (!en) begin
        cnt_d[i]   = '0;
        level_d[i] = 1'b0;
      end
      press_d[i]   = level_d[i] & ~level_q[i];
      // Forcing the level low on disable is not an accepted release.
      release_d[i] = en & level_q[i] & ~level_d[i];
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RptMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] RptDelayM1  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodM1 = RptW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0][RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  // Phase 0 waits REPEAT_DELAY after the press, phase 1 paces REPEAT_PERIOD.
  logic [NUM_BTN-1:0]           rpt_phase_q, rpt_phase_d;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (en && level_q[i] && level_d[i]) begin
        if (rpt_cnt_q[i] == (rpt_phase_q[i] ? RptPeriodM1 : RptDelayM1)) begin
          rpt_fire[i]    = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_phase_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end else begin
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= '0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_fire = '0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d | rpt_fire;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_conditioner;

  localparam int unsigned NB = 5;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; btn_in = '1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (btn_level !== 5'b00000 || btn_press !== 5'b00000 || btn_release !== 5'b00000) begin
      $display("FAIL reset_hold got lvl=%b prs=%b rel=%b want all 00000",
               btn_level, btn_press, btn_release);
      n_fail++;
    end
    nrst = 1'b1;
    tick();
    n_tests++;
    if (btn_level !== 5'b00000 || btn_press !== 5'b00000 || btn_release !== 5'b00000) begin
      $display("FAIL reset_first_cycle got lvl=%b prs=%b rel=%b want all 00000",
               btn_level, btn_press, btn_release);
      n_fail++;
    end
    btn_in = '0;
    repeat (10) tick();
    n_tests++;
    if (btn_level !== 5'b00000) begin
      $display("FAIL reset_settle got lvl=%b want 00000", btn_level);
      n_fail++;
    end
  endtask

  task automatic test_clean_press();
    logic [NB-1:0] exp_l, exp_p;
    btn_in = 5'b00001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_l = (k >= 6) ? 5'b00001 : 5'b00000;
      exp_p = (k == 6) ? 5'b00001 : 5'b00000;
      n_tests++;
      if (btn_level !== exp_l || btn_press !== exp_p || btn_release !== 5'b00000) begin
        $display("FAIL clean_press k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=00000",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
        n_fail++;
      end
    end
    btn_in = 5'b00000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_l = (k >= 6) ? 5'b00000 : 5'b00001;
      exp_p = (k == 6) ? 5'b00001 : 5'b00000;
      n_tests++;
      if (btn_level !== exp_l || btn_release !== exp_p || btn_press !== 5'b00000) begin
        $display("FAIL clean_release k=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=00000 rel=%b",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
        n_fail++;
      end
    end
  endtask

  task automatic test_bounce();
    int bad = 0;
    btn_in = 5'b00100;
    repeat (3) begin
      tick();
      if (btn_level !== 5'b0 || btn_press !== 5'b0 || btn_release !== 5'b0) bad++;
    end
    btn_in = 5'b00000;
    repeat (10) begin
      tick();
      if (btn_level !== 5'b0 || btn_press !== 5'b0 || btn_release !== 5'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      $display("FAIL bounce got %0d cycles with nonzero outputs want 0", bad);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] exp_p;
    btn_in = 5'b10010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k == 6) ? 5'b10010 : 5'b00000;
      n_tests++;
      if (btn_press !== exp_p || btn_release !== 5'b00000) begin
        $display("FAIL simul_press k=%0d got prs=%b rel=%b want prs=%b rel=00000",
                 k, btn_press, btn_release, exp_p);
        n_fail++;
      end
    end
    btn_in = 5'b00000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k == 6) ? 5'b10010 : 5'b00000;
      n_tests++;
      if (btn_release !== exp_p || btn_press !== 5'b00000) begin
        $display("FAIL simul_release k=%0d got prs=%b rel=%b want prs=00000 rel=%b",
                 k, btn_press, btn_release, exp_p);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [NB-1:0] exp_p;
    btn_in = 5'b00001;
    repeat (8) tick();
    n_tests++;
    if (btn_level !== 5'b00001) begin
      $display("FAIL rst_mid_pre got lvl=%b want 00001", btn_level);
      n_fail++;
    end
    btn_in = 5'b00011;
    repeat (3) tick();
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if (btn_level !== 5'b0 || btn_press !== 5'b0 || btn_release !== 5'b0) begin
      $display("FAIL rst_mid_async got lvl=%b prs=%b rel=%b want all 00000",
               btn_level, btn_press, btn_release);
      n_fail++;
    end
    #2 nrst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k == 6) ? 5'b00011 : 5'b00000;
      n_tests++;
      if (btn_press !== exp_p) begin
        $display("FAIL rst_mid_repress k=%0d got prs=%b want %b", k, btn_press, exp_p);
        n_fail++;
      end
    end
    btn_in = 5'b00000;
    repeat (10) tick();
  endtask

  task automatic test_enable_gating();
    int bad = 0;
    int hits = 0;
    int hit_k = 0;
    en = 1'b0;
    btn_in = 5'b11111;
    repeat (50) begin
      tick();
      if (btn_level !== 5'b0 || btn_press !== 5'b0 || btn_release !== 5'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      $display("FAIL en_low got %0d cycles with nonzero outputs want 0", bad);
      n_fail++;
    end
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (btn_press !== 5'b00000) begin
        hits++;
        hit_k = k;
        n_tests++;
        if (btn_press !== 5'b11111) begin
          $display("FAIL en_rise_value k=%0d got prs=%b want 11111", k, btn_press);
          n_fail++;
        end
      end
    end
    n_tests++;
    if (hits !== 1 || hit_k < DB || hit_k > DB + 1) begin
      $display("FAIL en_rise_pulse got %0d pulses at edge %0d want 1 pulse at edge %0d..%0d",
               hits, hit_k, DB, DB + 1);
      n_fail++;
    end
    n_tests++;
    if (btn_level !== 5'b11111) begin
      $display("FAIL en_rise_level got lvl=%b want 11111", btn_level);
      n_fail++;
    end
    en = 1'b0;
    tick();
    n_tests++;
    if (btn_level !== 5'b00000 || btn_release !== 5'b00000) begin
      $display("FAIL en_fall got lvl=%b rel=%b want 00000 00000", btn_level, btn_release);
      n_fail++;
    end
    btn_in = 5'b00000;
    en = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_autorepeat();
    logic exp_p, exp_r;
    btn_in = 5'b01000;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp_p = (k == 6);
`ifdef BUTTON_AUTOREPEAT_EN
      if (k >= 6 + RD && k <= 41 && ((k - 6 - RD) % RP) == 0) exp_p = 1'b1;
`endif
      exp_r = (k == 46);
      n_tests++;
      if (btn_press[3] !== exp_p || btn_release[3] !== exp_r) begin
        $display("FAIL autorepeat k=%0d got prs3=%b rel3=%b want prs3=%b rel3=%b",
                 k, btn_press[3], btn_release[3], exp_p, exp_r);
        n_fail++;
      end
      if (k == 40) btn_in = 5'b00000;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_enable_gating();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
